// File: rtl/iter_div_unit.sv
// Radix-2 restoring divide/remainder unit, one quotient bit per clock.
// Signed operands are divided as magnitudes and the result sign-corrected at the last step.
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_rem,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Handshake: start is accepted on any rising edge where the unit is in IDLE or
    // DONE; done pulses for one cycle with result/div_by_zero valid in that cycle.
    state_t           state;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg;
    logic             r_neg;
    logic             op_rem_q;
    logic             fast_q;
    logic [WIDTH-1:0] fast_res_q;
    logic             fast_dbz_q;

    assign fsm_state = state;

    // Operand conditioning at the capture edge
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             b_zero;
    logic             ovf;
    logic [WIDTH-1:0] fast_res;

    assign a_neg    = is_signed & A[WIDTH-1];
    assign b_neg    = is_signed & B[WIDTH-1];
    assign a_abs    = a_neg ? -A : A;
    assign b_abs    = b_neg ? -B : B;
    assign b_zero   = (B == '0);
    assign ovf      = is_signed & (A == MIN_NEG) & (B == '1);
    assign fast_res = b_zero ? (op_rem ? A : '1) : (op_rem ? '0 : A);

    // One restoring step; the WIDTH+1 bit difference carries the trial sign.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] final_res;

    assign shifted   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, div_q};
    assign rem_nx    = diff[WIDTH] ? shifted : diff;
    assign quo_nx    = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign q_fix     = q_neg ? -quo_nx : quo_nx;
    assign r_fix     = r_neg ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
    assign final_res = op_rem_q ? r_fix : q_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            op_rem_q    <= 1'b0;
            fast_q      <= 1'b0;
            fast_res_q  <= '0;
            fast_dbz_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (fast_q) begin
                        result      <= fast_res_q;
                        div_by_zero <= fast_dbz_q;
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            result      <= final_res;
                            div_by_zero <= 1'b0;
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        quo_q      <= a_abs;
                        div_q      <= b_abs;
                        rem_q      <= '0;
                        cnt_q      <= CNT_W'(WIDTH);
                        q_neg      <= a_neg ^ b_neg;
                        r_neg      <= a_neg;
                        op_rem_q   <= op_rem;
                        fast_q     <= b_zero | ovf;
                        fast_res_q <= fast_res;
                        fast_dbz_q <= b_zero;
                        state      <= RUN;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: vector table, handshake corner cases and mid-run reset.
module tb_iter_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_rem;
    logic         is_signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;
    logic [1:0]   fsm_state;

    iter_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_rem      (op_rem),
        .is_signed   (is_signed),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .fsm_state   (fsm_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         rem;
        logic         sgn;
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Driver: present operands and pulse start across one rising edge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic rem, input logic sgn);
        @(negedge clk);
        A = a; B = b; op_rem = rem; is_signed = sgn; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts cycles after the start edge.
    // poke > 0 re-asserts start with other operands in that cycle.
    task automatic wait_done(input int poke, output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (lat == poke) begin
                start = 1'b1; A = 32'd5; B = 32'd1; op_rem = 1'b1; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int bc;
        int done_seen;
        vec_t v;

        reset = 1'b1; start = 1'b0; op_rem = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_done",  {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_dbz",   {31'd0, div_by_zero}, 32'd0);
        check_eq("rst_state", {30'd0, fsm_state}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        vecs.push_back('{32'd100,       32'd7,        1'b0, 1'b0, 32'd14,        1'b0, 33});
        vecs.push_back('{32'd100,       32'd7,        1'b1, 1'b0, 32'd2,         1'b0, 33});
        vecs.push_back('{32'hFFFFFFF9,  32'd2,        1'b0, 1'b1, 32'hFFFFFFFD,  1'b0, 33});
        vecs.push_back('{32'hFFFFFFF9,  32'd2,        1'b1, 1'b1, 32'hFFFFFFFF,  1'b0, 33});
        vecs.push_back('{32'd7,         32'hFFFFFFFE, 1'b0, 1'b1, 32'hFFFFFFFD,  1'b0, 33});
        vecs.push_back('{32'd7,         32'hFFFFFFFE, 1'b1, 1'b1, 32'd1,         1'b0, 33});
        vecs.push_back('{32'hFFFFFF9C,  32'hFFFFFFF9, 1'b0, 1'b1, 32'd14,        1'b0, 33});
        vecs.push_back('{32'hFFFFFF9C,  32'hFFFFFFF9, 1'b1, 1'b1, 32'hFFFFFFFE,  1'b0, 33});
        vecs.push_back('{32'h12345678,  32'd0,        1'b0, 1'b1, 32'hFFFFFFFF,  1'b1, 2});
        vecs.push_back('{32'h12345678,  32'd0,        1'b1, 1'b1, 32'h12345678,  1'b1, 2});
        vecs.push_back('{32'h12345678,  32'd0,        1'b0, 1'b0, 32'hFFFFFFFF,  1'b1, 2});
        vecs.push_back('{32'h12345678,  32'd0,        1'b1, 1'b0, 32'h12345678,  1'b1, 2});
        vecs.push_back('{32'h80000000,  32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000,  1'b0, 2});
        vecs.push_back('{32'h80000000,  32'hFFFFFFFF, 1'b1, 1'b1, 32'd0,         1'b0, 2});
        vecs.push_back('{32'h80000000,  32'hFFFFFFFF, 1'b0, 1'b0, 32'd0,         1'b0, 33});
        vecs.push_back('{32'h80000000,  32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000,  1'b0, 33});
        vecs.push_back('{32'd9,         32'd3,        1'b0, 1'b0, 32'd3,         1'b0, 33});

        foreach (vecs[i]) begin
            v = vecs[i];
            exp_q.push_back(v.res);
            launch(v.a, v.b, v.rem, v.sgn);
            wait_done(0, lat, bc);
            check_eq($sformatf("v%0d_lat", i), lat, v.lat);
            check_eq($sformatf("v%0d_busy", i), bc, v.lat - 1);
            check_eq($sformatf("v%0d_res", i), result, exp_q.pop_front());
            check_eq($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, v.dbz});
            A = $urandom_range(0, 1000); B = $urandom_range(0, 1000);
            @(posedge clk);
            #1;
            check_eq($sformatf("v%0d_done_1cyc", i), {31'd0, done}, 32'd0);
            check_eq($sformatf("v%0d_idle", i), {30'd0, fsm_state}, 32'd0);
            check_eq($sformatf("v%0d_hold", i), result, v.res);
        end

        // start during RUN is ignored
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        wait_done(5, lat, bc);
        check_eq("ign_lat", lat, 33);
        check_eq("ign_res", result, 32'd14);

        // start held in the DONE cycle launches back-to-back
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        wait_done(0, lat, bc);
        check_eq("b2b_first", result, 32'd14);
        A = 32'd9; B = 32'd3; op_rem = 1'b0; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(0, lat, bc);
        check_eq("b2b_sep", lat, 33);
        check_eq("b2b_second", result, 32'd3);

        // asynchronous reset ten cycles into RUN
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_busy",   {31'd0, busy}, 32'd0);
        check_eq("mid_done",   {31'd0, done}, 32'd0);
        check_eq("mid_result", result, 32'd0);
        check_eq("mid_state",  {30'd0, fsm_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check_eq("mid_no_done", done_seen, 0);
        launch(32'd9, 32'd3, 1'b0, 1'b0);
        wait_done(0, lat, bc);
        check_eq("post_rst_lat", lat, 33);
        check_eq("post_rst_res", result, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
